// File: rtl/ipsxe_fft_frame_gen_pkg.sv
// Shared helpers and FSM encoding for the FFT test-frame generator and its source ROM.
package ipsxe_fft_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Sample parts are padded up to a whole number of bytes on the AXI4-Stream bus.
  function automatic int datain_width(input int input_width);
    return 8 * ((input_width + 7) / 8);
  endfunction

  function automatic int fft_len(input int log2_fft_len);
    return 1 << log2_fft_len;
  endfunction

  // A single-frame test still needs a one-bit frame counter.
  function automatic int frm_idx_width(input int frame_num);
    return (clog2(frame_num) < 1) ? 1 : clog2(frame_num);
  endfunction

endpackage

// File: rtl/ipsxe_fft_src_rom.sv
// Source sample ROM: entry k holds re = k, im = -k.
module ipsxe_fft_src_rom #(
  parameter int LOG2_FFT_LEN = 4,
  parameter int INPUT_WIDTH  = 16
) (
  input  logic [LOG2_FFT_LEN-1:0]  rd_addr,
  output logic [2*INPUT_WIDTH-1:0] rd_data
);

  logic [INPUT_WIDTH-1:0] re;
  logic [INPUT_WIDTH-1:0] im;

  always_comb begin
    re      = INPUT_WIDTH'(rd_addr);
    im      = -re;
    rd_data = {im, re};
  end

endmodule

// File: rtl/ipsxe_fft_frame_gen.sv
// Test-frame generator: per frame one config beat, then N samples from the source ROM.
module ipsxe_fft_frame_gen
  import ipsxe_fft_frame_gen_pkg::*;
#(
  parameter int TEST_FRAME_NUM = 10,
  parameter int LOG2_FFT_LEN   = 4,
  parameter int INPUT_WIDTH    = 16
) (
  input  logic                                   i_aclk,
  input  logic                                   i_aresetn,
  input  logic                                   i_aclken,
  input  logic                                   i_start_test,
  output logic                                   o_axi4s_cfg_tvalid,
  output logic [7:0]                             o_axi4s_cfg_tdata,
  output logic                                   o_axi4s_data_tvalid,
  output logic [2*datain_width(INPUT_WIDTH)-1:0] o_axi4s_data_tdata,
  output logic                                   o_axi4s_data_tlast,
  input  logic                                   i_axi4s_data_tready,
  output logic                                   o_gen_finished
);

  localparam int DW       = datain_width(INPUT_WIDTH);
  localparam int N        = fft_len(LOG2_FFT_LEN);
  localparam int FW       = frm_idx_width(TEST_FRAME_NUM);
  localparam int LAST_FRM = TEST_FRAME_NUM - 1;
  localparam logic [LOG2_FFT_LEN-1:0] SMP_LAST = LOG2_FFT_LEN'(N - 1);

  // NOTE: declaration initialisers give power-up values matching reset, for flows that never assert reset.
  state_t                  state          = ST_IDLE;
  logic [FW-1:0]           frm_idx        = '0;
  logic [LOG2_FFT_LEN-1:0] smp_idx        = '0;
  logic                    cfg_tvalid_q   = 1'b0;
  logic [7:0]              cfg_tdata_q    = '0;
  logic                    data_tvalid_q  = 1'b0;
  logic [2*DW-1:0]         data_tdata_q   = '0;
  logic                    data_tlast_q   = 1'b0;
  logic                    gen_finished_q = 1'b1;

  logic [LOG2_FFT_LEN-1:0]  smp_next;
  logic [FW-1:0]            frm_next;
  logic [LOG2_FFT_LEN-1:0]  rom_addr;
  logic [2*INPUT_WIDTH-1:0] rom_data;
  logic signed [INPUT_WIDTH-1:0] rom_re;
  logic signed [INPUT_WIDTH-1:0] rom_im;
  logic [2*DW-1:0]          rom_word;

  assign smp_next = smp_idx + LOG2_FFT_LEN'(1);
  assign frm_next = frm_idx + FW'(1);

  // The ROM looks one sample ahead in DATA so back-to-back transfers need no bubble;
  // outside DATA it presents sample 0 for the first beat of the next frame.
  assign rom_addr = (state == ST_DATA) ? smp_next : '0;

  ipsxe_fft_src_rom #(
    .LOG2_FFT_LEN (LOG2_FFT_LEN),
    .INPUT_WIDTH  (INPUT_WIDTH)
  ) u_src_rom (
    .rd_addr (rom_addr),
    .rd_data (rom_data)
  );

  assign rom_re   = rom_data[INPUT_WIDTH-1:0];
  assign rom_im   = rom_data[2*INPUT_WIDTH-1:INPUT_WIDTH];
  assign rom_word = {DW'(rom_im), DW'(rom_re)};

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state          <= ST_IDLE;
      frm_idx        <= '0;
      smp_idx        <= '0;
      cfg_tvalid_q   <= 1'b0;
      cfg_tdata_q    <= '0;
      data_tvalid_q  <= 1'b0;
      data_tdata_q   <= '0;
      data_tlast_q   <= 1'b0;
      gen_finished_q <= 1'b1;
    end else if (i_aclken) begin
      if (i_start_test) begin
        // A start in any state (re)starts the test; a partial frame is simply dropped.
        state          <= ST_CFG;
        frm_idx        <= '0;
        smp_idx        <= '0;
        cfg_tvalid_q   <= 1'b1;
        cfg_tdata_q    <= 8'h01;
        data_tvalid_q  <= 1'b0;
        data_tlast_q   <= 1'b0;
        gen_finished_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_CFG: begin
            state         <= ST_DATA;
            cfg_tvalid_q  <= 1'b0;
            data_tvalid_q <= 1'b1;
            data_tdata_q  <= rom_word;
            data_tlast_q  <= (smp_idx == SMP_LAST);
          end
          ST_DATA: begin
            if (i_axi4s_data_tready) begin
              if (smp_idx == SMP_LAST) begin
                smp_idx       <= '0;
                data_tvalid_q <= 1'b0;
                data_tlast_q  <= 1'b0;
                if (int'(frm_idx) < LAST_FRM) begin
                  frm_idx      <= frm_next;
                  state        <= ST_CFG;
                  cfg_tvalid_q <= 1'b1;
                  cfg_tdata_q  <= {7'd0, ~frm_next[0]};
                end else begin
                  state          <= ST_IDLE;
                  gen_finished_q <= 1'b1;
                end
              end else begin
                smp_idx      <= smp_next;
                data_tdata_q <= rom_word;
                data_tlast_q <= (smp_next == SMP_LAST);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_axi4s_cfg_tvalid  = cfg_tvalid_q;
  assign o_axi4s_cfg_tdata   = cfg_tdata_q;
  assign o_axi4s_data_tvalid = data_tvalid_q;
  assign o_axi4s_data_tdata  = data_tdata_q;
  assign o_axi4s_data_tlast  = data_tlast_q;
  assign o_gen_finished      = gen_finished_q;

endmodule

// File: tb/tb_ipsxe_fft_frame_gen.sv
// Self-checking bench: the expected output stream is modelled as a flat list of test beats.
module tb_ipsxe_fft_frame_gen;

  localparam int TFN   = 10;
  localparam int L2N   = 4;
  localparam int IW    = 16;
  localparam int DW    = 16;
  localparam int N     = 16;
  localparam int FL    = N + 1;
  localparam int TOTAL = TFN * FL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aclken = 1'b0;
  logic          start = 1'b0;
  logic          tready = 1'b0;
  logic          cfg_tvalid;
  logic [7:0]    cfg_tdata;
  logic          data_tvalid;
  logic [2*DW-1:0] data_tdata;
  logic          data_tlast;
  logic          gen_finished;

  int total = 0;
  int bad = 0;
  int cfg_seen = 0;
  int data_seen = 0;
  int tlast_seen = 0;

  // Reference: position within the test's beat list (frame f occupies FL beats: cfg then N samples).
  bit m_active = 1'b0;
  int m_pos = 0;

  always #5 clk = ~clk;

  ipsxe_fft_frame_gen #(
    .TEST_FRAME_NUM (TFN),
    .LOG2_FFT_LEN   (L2N),
    .INPUT_WIDTH    (IW)
  ) dut (
    .i_aclk              (clk),
    .i_aresetn           (rst_n),
    .i_aclken            (aclken),
    .i_start_test        (start),
    .o_axi4s_cfg_tvalid  (cfg_tvalid),
    .o_axi4s_cfg_tdata   (cfg_tdata),
    .o_axi4s_data_tvalid (data_tvalid),
    .o_axi4s_data_tdata  (data_tdata),
    .o_axi4s_data_tlast  (data_tlast),
    .i_axi4s_data_tready (tready),
    .o_gen_finished      (gen_finished)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int  o;
    int  k;
    logic [DW-1:0] re_e;
    logic [DW-1:0] im_e;
    o = m_pos % FL;
    k = o - 1;
    chk("cfg_tvalid", cfg_tvalid, m_active && (o == 0));
    chk("data_tvalid", data_tvalid, m_active && (o != 0));
    chk("gen_finished", gen_finished, !m_active);
    if (m_active && o == 0)
      chk("cfg_tdata", cfg_tdata, ((m_pos / FL) % 2 == 0) ? 8'h01 : 8'h00);
    if (m_active && o != 0) begin
      re_e = DW'(k);
      im_e = DW'(-k);
      chk("data_tdata", data_tdata, {im_e, re_e});
      chk("data_tlast", data_tlast, k == N - 1);
    end
  endtask

  task automatic model_edge(input bit st, input bit rdy, input bit en);
    if (!rst_n) begin
      m_active = 1'b0;
      m_pos    = 0;
    end else if (en) begin
      if (st) begin
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_active) begin
        if (m_pos % FL == 0 || rdy) m_pos++;
        if (m_pos == TOTAL) begin
          m_active = 1'b0;
          m_pos    = 0;
        end
      end
    end
  endtask

  task automatic step(input bit st, input bit rdy, input bit en);
    start  = st;
    tready = rdy;
    aclken = en;
    @(posedge clk);
    model_edge(st, rdy, en);
    #1;
    check_outputs();
    if (cfg_tvalid) cfg_seen++;
    if (data_tvalid) data_seen++;
    if (data_tvalid && data_tlast) tlast_seen++;
    start = 1'b0;
  endtask

  task automatic run_until(input int target);
    int b;
    b = 0;
    while (m_active && m_pos != target && b < 1000) begin
      step(1'b0, 1'b1, 1'b1);
      b++;
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (m_active && b < budget) begin
      step(1'b0, 1'b1, 1'b1);
      b++;
    end
    chk("drain_finished", gen_finished, 1'b1);
  endtask

  initial begin
    int n;
    bit t;

    // Reset values.
    #1;
    chk("rst_cfg_tvalid", cfg_tvalid, 1'b0);
    chk("rst_cfg_tdata", cfg_tdata, 8'h00);
    chk("rst_data_tvalid", data_tvalid, 1'b0);
    chk("rst_data_tdata", data_tdata, '0);
    chk("rst_tlast", data_tlast, 1'b0);
    chk("rst_finished", gen_finished, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    // Full test with tready held high: 170 cycles, 10 cfg beats, 160 samples, 10 tlasts.
    cfg_seen = 0; data_seen = 0; tlast_seen = 0;
    step(1'b1, 1'b1, 1'b1);
    n = 0;
    while (!gen_finished && n < 400) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("a_cycles", n, TOTAL);
    chk("a_cfg_beats", cfg_seen, TFN);
    chk("a_samples", data_seen, TFN * N);
    chk("a_tlasts", tlast_seen, TFN);

    // A start with the clock enable low is ignored.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);

    // tready toggling every cycle: samples hold while stalled.
    step(1'b1, 1'b1, 1'b1);
    t = 1'b1;
    n = 0;
    while (m_active && n < 800) begin
      step(1'b0, t, 1'b1);
      t = !t;
      n++;
    end
    chk("b_finished", gen_finished, 1'b1);

    // Abort at sample 7 of frame 3; the restarted test still produces 10 full frames.
    step(1'b1, 1'b1, 1'b1);
    run_until(3 * FL + 1 + 7);
    cfg_seen = 0; tlast_seen = 0;
    step(1'b1, 1'b1, 1'b1);
    chk("c_abort_tvalid", data_tvalid, 1'b0);
    chk("c_abort_cfg", cfg_tdata, 8'h01);
    drain(400);
    chk("c_cfg_beats", cfg_seen, TFN);
    chk("c_tlasts", tlast_seen, TFN);

    // Clock enable low for 3 cycles mid-frame.
    step(1'b1, 1'b1, 1'b1);
    run_until(1 * FL + 1 + 5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    drain(400);

    // Asynchronous reset in the middle of frame 5.
    step(1'b1, 1'b1, 1'b1);
    run_until(5 * FL + 1 + 4);
    #2 rst_n = 1'b0;
    #1;
    m_active = 1'b0;
    m_pos    = 0;
    check_outputs();
    chk("e_rst_tlast", data_tlast, 1'b0);
    chk("e_rst_tdata", data_tdata, '0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);

    // Randomised back-pressure, clock enable and occasional restarts.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
